axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default `ADDR_WIDTH, the AXI address width.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default `DATA_WIDTH, the beat width.
REQ-003 The block SHALL expose parameter DEPTH_LOG2, default 14, the log2 of backing-RAM depth in words.
REQ-004 The block SHALL expose parameter READ_LATENCY, default 4, the cycles from AR accept to the first R beat (range 1..15).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  AWVALID/AWREADY  in/out  1/1  write-address handshake
  AWID, AWLEN  in  4, 4  write burst id; beats minus one
  AWADDR  in  ADDR_WIDTH  word address of first write beat
  WVALID/WREADY  in/out  1/1  write-data handshake
  WLAST, WID  in  1, 4  last write beat; beat id
  WDATA  in  DATA_WIDTH  write beat data
  BVALID/BREADY  out/in  1/1  write-response handshake
  BID  out  4  id of completed write burst
  ARVALID/ARREADY  in/out  1/1  read-address handshake
  ARID, ARLEN  in  4, 4  read burst id; beats minus one
  ARADDR  in  ADDR_WIDTH  word address of first read beat
  RVALID/RREADY  out/in  1/1  read-data handshake
  RLAST, RID  out  1, 4  last read beat; burst id
  RDATA  out  DATA_WIDTH  read beat data
  protocol_err  out  1  sticky: WID/AWID mismatch or WLAST beat-count mismatch

Function
REQ-006 A transfer SHALL occur on a rising clk edge where VALID and READY are both 1; neither side's VALID may depend on READY.
REQ-007 Backing RAM index SHALL be address[DEPTH_LOG2-1:0]; upper bits are ignored; the index increments by one per beat and wraps modulo 2^DEPTH_LOG2.
REQ-008 The write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM R_IDLE, R_WAIT, R_BURST; both run independently and concurrently.
REQ-009 W_IDLE: AWREADY=1; on AW handshake, latch AWID/AWLEN/AWADDR, clear beat count, go to W_DATA.
REQ-010 W_DATA: WREADY=1; each W handshake writes WDATA to the current index, then increments index and count.
REQ-011 The W handshake with WLAST=1 SHALL end the burst (go to W_RESP); if count != AWLEN at that beat, set protocol_err.
REQ-012 In W_DATA, beats after AWLEN+1 without WLAST SHALL be written (index keeps wrapping) and SHALL set protocol_err.
REQ-013 Any W beat with WID != latched AWID SHALL set protocol_err; the data is still written.
REQ-014 W_RESP: BVALID=1 and BID=latched AWID, held until the B handshake, then W_IDLE; AWREADY=0 outside W_IDLE.
REQ-015 R_IDLE: ARREADY=1; on AR handshake, latch ARID/ARLEN/ARADDR, load latency counter with READY_LATENCY-1, go to R_WAIT.
REQ-016 R_WAIT SHALL decrement the counter each cycle; at zero, register RDATA from the current index and go to R_BURST, so the first RVALID is READ_LATENCY cycles after the AR handshake edge.
REQ-017 R_BURST: RVALID=1, RID=latched ARID, RLAST=1 exactly on beat ARLEN; RDATA/RLAST/RID SHALL be stable while RVALID=1 and RREADY=0.
REQ-018 On each non-last R handshake, the next beat's RDATA SHALL be registered that edge from the incremented index (no bubbles while RREADY=1); after the RLAST handshake, go to R_IDLE.
REQ-019 When a write and a read hit the same index on the same edge, the registered RDATA SHALL be the pre-write (old) word.
REQ-020 ARLEN=0 and AWLEN=0 SHALL be single-beat bursts; LEN=15 SHALL give 16 beats.
REQ-021 protocol_err SHALL stay 1 until reset once set.

Reset
REQ-022 While rst_n=0, asynchronously: both FSMs idle; AWREADY=ARREADY=0 during reset, 1 on the first cycle after release; WREADY, BVALID, RVALID, RLAST, protocol_err=0; BID, RID, RDATA=0.
REQ-023 Reset SHALL NOT clear RAM contents; a reset mid-burst SHALL abandon the burst with no B or R response.

Verification
REQ-024 Write AWADDR=0x10, AWLEN=3, WDATA 0xA0..0xA3, BREADY=1 -> BVALID one cycle after WLAST beat, BID=AWID; subsequent read ARLEN=3 returns 0xA0..0xA3, RLAST on 4th beat.
REQ-025 Read ARLEN=0 with READ_LATENCY=4 -> RVALID exactly 4 cycles after AR handshake; RREADY held low 5 cycles -> RDATA, RLAST=1 unchanged throughout.
REQ-026 Write at index 2^DEPTH_LOG2-2, AWLEN=3 -> words land at indices max-1, max, 0, 1; readback matches.
REQ-027 AWLEN=3 but WLAST on beat 2 -> burst ends, B issued, protocol_err=1 and stays 1; WID!=AWID on a clean burst also sets it.
REQ-028 Concurrent read and write bursts to the same index -> both complete; the read beat registered on the write edge returns the old word.
REQ-029 rst_n pulsed low mid read burst -> RVALID drops immediately; after release ARREADY=1 and RAM contents preserved.

Source files
------------

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: simplified AXI-style memory slave. It contains one
// word-addressed RAM with independent write and read engines.
// Handshake rule for every channel (AW, W, B, AR, R): a beat transfers on a
// rising clk edge where VALID and READY are both 1. VALID never depends on
// READY. Once VALID is raised by this block, the payload stays stable until
// the transfer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_mem_slave #(
    parameter int ADDR_WIDTH   = `ADDR_WIDTH,
    parameter int DATA_WIDTH   = `DATA_WIDTH,
    parameter int DEPTH_LOG2   = 14,
    parameter int READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [3:0]            AWID,
    input  logic [3:0]            AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic                  WLAST,
    input  logic [3:0]            WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [3:0]            BID,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [3:0]            ARID,
    input  logic [3:0]            ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RLAST,
    output logic [3:0]            RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  protocol_err,
    output logic [1:0]            w_state_dbg,
    output logic [1:0]            r_state_dbg
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_BURST = 2'd2} r_state_t;

    localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = DEPTH_LOG2'(1);
    localparam logic [3:0]            LAT_INIT = 4'(READ_LATENCY - 1);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic                  ready_en;
    logic [3:0]            w_id, w_len;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [4:0]            w_cnt;
    logic [3:0]            r_id, r_len, r_beat, lat_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  unused_addr_bits;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign b_hs  = BVALID && BREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;

    assign BID         = w_id;
    assign RID         = r_id;
    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

    // Only the low DEPTH_LOG2 address bits select a word.
    assign unused_addr_bits = ^{AWADDR[ADDR_WIDTH-1:DEPTH_LOG2], ARADDR[ADDR_WIDTH-1:DEPTH_LOG2]};

    // Hold the address READYs low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // RAM storage; reset leaves contents untouched.
    always_ff @(posedge clk) begin
        if (w_hs) mem[w_idx] <= WDATA;
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write FSM next state: address, data beats until WLAST, then response.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)          w_next = W_DATA;
            W_DATA:  if (w_hs && WLAST)  w_next = W_RESP;
            W_RESP:  if (b_hs)           w_next = W_IDLE;
            default:                     w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs, decoded from state.
    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (w_state)
            W_IDLE:  AWREADY = ready_en;
            W_DATA:  WREADY  = 1'b1;
            W_RESP:  BVALID  = 1'b1;
            default: ;
        endcase
    end

    // Write burst context: id, length, word index, beat count and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_id         <= '0;
            w_len        <= '0;
            w_idx        <= '0;
            w_cnt        <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (aw_hs) begin
                w_id  <= AWID;
                w_len <= AWLEN;
                w_idx <= AWADDR[DEPTH_LOG2-1:0];
                w_cnt <= '0;
            end
            if (w_hs) begin
                w_idx <= w_idx + IDX_ONE;
                // Saturate so an overlong burst can never alias back to a legal count.
                if (w_cnt != 5'd31) w_cnt <= w_cnt + 5'd1;
                if (WID != w_id) protocol_err <= 1'b1;
                if (WLAST ? (w_cnt != {1'b0, w_len}) : (w_cnt > {1'b0, w_len}))
                    protocol_err <= 1'b1;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read FSM next state: address, latency countdown, then beats until RLAST.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)          r_next = R_WAIT;
            R_WAIT:  if (lat_cnt == 4'd0) r_next = R_BURST;
            R_BURST: if (r_hs && RLAST)  r_next = R_IDLE;
            default:                     r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs, decoded from state.
    always_comb begin
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        case (r_state)
            R_IDLE:  ARREADY = ready_en;
            R_BURST: RVALID  = 1'b1;
            default: ;
        endcase
    end

    // Read burst context and the registered R payload. The RAM is sampled on
    // the same edge as any write, so a colliding write yields the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_beat  <= '0;
            lat_cnt <= '0;
            RDATA   <= '0;
            RLAST   <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id    <= ARID;
                r_len   <= ARLEN;
                r_idx   <= ARADDR[DEPTH_LOG2-1:0];
                r_beat  <= '0;
                lat_cnt <= LAT_INIT;
            end
            if (r_state == R_WAIT) begin
                if (lat_cnt == 4'd0) begin
                    RDATA <= mem[r_idx];
                    RLAST <= (r_len == 4'd0);
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
            end
            if (r_hs) begin
                if (RLAST) begin
                    RLAST <= 1'b0;
                end else begin
                    r_idx  <= r_idx + IDX_ONE;
                    r_beat <= r_beat + 4'd1;
                    RDATA  <= mem[r_idx + IDX_ONE];
                    RLAST  <= ((r_beat + 4'd1) == r_len);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
`timescale 1ns/1ps
// tb_axi_mem_slave: directed and randomized bursts against a word-array model.
module tb_axi_mem_slave;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DL    = 14;
    localparam int LAT   = 4;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          AWVALID = 1'b0, AWREADY;
    logic [3:0]    AWID = '0, AWLEN = '0;
    logic [AW-1:0] AWADDR = '0;
    logic          WVALID = 1'b0, WREADY, WLAST = 1'b0;
    logic [3:0]    WID = '0;
    logic [DW-1:0] WDATA = '0;
    logic          BVALID, BREADY = 1'b1;
    logic [3:0]    BID;
    logic          ARVALID = 1'b0, ARREADY;
    logic [3:0]    ARID = '0, ARLEN = '0;
    logic [AW-1:0] ARADDR = '0;
    logic          RVALID, RREADY = 1'b0, RLAST;
    logic [3:0]    RID;
    logic [DW-1:0] RDATA;
    logic          protocol_err;
    logic [1:0]    w_state_dbg, r_state_dbg;

    axi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
        .protocol_err(protocol_err), .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Run bound.
    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_q[$];
    logic          exp_err = 1'b0;

    function automatic int idx(input logic [AW-1:0] a);
        return int'(a) & (DEPTH - 1);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_perr", protocol_err, 0);
        check("rst_bid", BID, 0);
        check("rst_rid", RID, 0);
        check("rst_rdata", RDATA, 0);
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_awready", AWREADY, 1);
        check("rel_arready", ARREADY, 1);
    endtask

    // nbeats may differ from awlen+1 to provoke protocol errors.
    task automatic write_burst(input logic [AW-1:0] addr, input logic [3:0] awlen, input int nbeats,
                               input logic [3:0] id, input logic [3:0] wid,
                               input bit seq, input logic [DW-1:0] base);
        int n;
        logic [DW-1:0] d;
        @(negedge clk);
        AWVALID = 1'b1; AWADDR = addr; AWID = id; AWLEN = awlen;
        n = 0;
        while (AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("awready", AWREADY, 1);
        @(negedge clk);
        AWVALID = 1'b0; AWADDR = $urandom; AWLEN = 4'($urandom);
        for (int i = 0; i < nbeats; i++) begin
            d = seq ? base + DW'(i) : DW'($urandom);
            WVALID = 1'b1; WDATA = d; WID = wid; WLAST = (i == nbeats - 1);
            check("wready", WREADY, 1);
            ref_mem[idx(addr + AW'(i))] = d;
            if (wid != id) exp_err = 1'b1;
            if ((i == nbeats - 1) ? (i != int'(awlen)) : (i > int'(awlen))) exp_err = 1'b1;
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("bvalid", BVALID, 1);
        check("bid", BID, id);
        @(negedge clk);
        check("bvalid_drop", BVALID, 0);
        check("awready_back", AWREADY, 1);
        check("perr", protocol_err, exp_err);
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input logic [3:0] arlen,
                              input logic [3:0] id, input int first_stall);
        int n;
        int stall;
        logic [DW-1:0] hd;
        logic hl;
        for (int i = 0; i <= int'(arlen); i++) exp_q.push_back(ref_mem[idx(addr + AW'(i))]);
        @(negedge clk);
        ARVALID = 1'b1; ARADDR = addr; ARID = id; ARLEN = arlen;
        n = 0;
        while (ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("arready", ARREADY, 1);
        @(negedge clk);
        ARVALID = 1'b0; ARADDR = $urandom;
        for (int k = 0; k < LAT; k++) begin
            check("rvalid_early", RVALID, 0);
            @(negedge clk);
        end
        check("rvalid_latency", RVALID, 1);
        for (int b = 0; b <= int'(arlen); b++) begin
            stall = (b == 0 && first_stall > 0) ? first_stall : int'($urandom_range(0, 2));
            hd = RDATA; hl = RLAST;
            RREADY = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("rvalid_hold", RVALID, 1);
                check("rdata_hold", RDATA, hd);
                check("rlast_hold", RLAST, hl);
                check("rid_hold", RID, id);
            end
            RREADY = 1'b1;
            check("rvalid", RVALID, 1);
            check("rdata", RDATA, exp_q.pop_front());
            check("rlast", RLAST, (b == int'(arlen)));
            check("rid", RID, id);
            @(negedge clk);
        end
        RREADY = 1'b0;
        check("rvalid_end", RVALID, 0);
        check("arready_end", ARREADY, 1);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [3:0] l;
        do_reset();

        // Basic burst write then readback.
        write_burst(32'h10, 4'd3, 4, 4'd5, 4'd5, 1'b1, 32'hA0);
        read_burst(32'h10, 4'd3, 4'd9, 0);

        // Single beat, long stall with RLAST held.
        read_burst(32'h10, 4'd0, 4'd2, 5);

        // Wrap at the top of the RAM, and upper address bits ignored.
        write_burst(AW'(DEPTH - 2), 4'd3, 4, 4'd1, 4'd1, 1'b0, '0);
        read_burst(AW'(DEPTH - 2), 4'd3, 4'd1, 0);
        read_burst(32'h8000_0000, 4'd1, 4'd4, 0);

        // Length extremes.
        write_burst(32'h1000, 4'd15, 16, 4'd7, 4'd7, 1'b0, '0);
        read_burst(32'h1000, 4'd15, 4'd7, 0);
        write_burst(32'h2000, 4'd0, 1, 4'd8, 4'd8, 1'b0, '0);
        read_burst(32'h2000, 4'd0, 4'd8, 0);

        // Random clean bursts.
        for (int it = 0; it < 6; it++) begin
            a = {AW'($urandom_range(0, 255)) << DL} | AW'($urandom_range(0, DEPTH - 1));
            l = 4'($urandom_range(0, 15));
            write_burst(a, l, int'(l) + 1, 4'(it), 4'(it), 1'b0, '0);
            read_burst(a, 4'($urandom_range(0, int'(l))), 4'(it + 3), 0);
        end

        // Early WLAST sets a sticky error.
        write_burst(32'h40, 4'd3, 3, 4'd1, 4'd1, 1'b0, '0);
        write_burst(32'h48, 4'd1, 2, 4'd2, 4'd2, 1'b0, '0);
        read_burst(32'h40, 4'd2, 4'd1, 0);

        // Reset keeps RAM; WID mismatch on a clean-length burst.
        do_reset();
        read_burst(32'h10, 4'd3, 4'd6, 0);
        write_burst(32'h60, 4'd1, 2, 4'd2, 4'd7, 1'b0, '0);

        // Overlong burst still writes every beat.
        do_reset();
        write_burst(32'h80, 4'd1, 4, 4'd3, 4'd3, 1'b0, '0);
        read_burst(32'h80, 4'd3, 4'd3, 0);

        // Concurrent write/read colliding on one index: the read sees the old word.
        do_reset();
        write_burst(32'h2FD, 4'd4, 5, 4'd1, 4'd1, 1'b0, '0);
        fork
            write_burst(32'h2FD, 4'd3, 4, 4'd2, 4'd2, 1'b0, '0);
            read_burst(32'h300, 4'd1, 4'd4, 0);
        join
        read_burst(32'h300, 4'd0, 4'd5, 0);

        // Reset in the middle of a read burst.
        write_burst(32'h200, 4'd7, 8, 4'd3, 4'd3, 1'b1, 32'h5000);
        @(negedge clk);
        ARVALID = 1'b1; ARADDR = 32'h200; ARID = 4'd3; ARLEN = 4'd7;
        check("mid_arready", ARREADY, 1);
        @(negedge clk);
        ARVALID = 1'b0; RREADY = 1'b1;
        repeat (LAT) @(negedge clk);
        check("mid_rvalid", RVALID, 1);
        check("mid_rdata0", RDATA, 32'h5000);
        @(negedge clk);
        check("mid_rdata1", RDATA, 32'h5001);
        RREADY = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            check("mid_no_r", RVALID, 0);
            @(negedge clk);
        end
        read_burst(32'h200, 4'd7, 4'd3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
